// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: L1 I/D request ports and shared L2 port seen by the arbiter
interface cache_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic              icache_resp;
  logic [LINE_W-1:0] icache_rdata;
  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic              dcache_resp;
  logic [LINE_W-1:0] dcache_rdata;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic              l2_resp;
  logic [LINE_W-1:0] l2_rdata;
  logic              arb_busy;
  modport slave (
    input  icache_read, icache_address, dcache_read, dcache_write, dcache_address,
           dcache_wdata, l2_resp, l2_rdata,
    output icache_resp, icache_rdata, dcache_resp, dcache_rdata, l2_read, l2_write,
           l2_address, l2_wdata, arb_busy
  );
  modport master (
    output icache_read, icache_address, dcache_read, dcache_write, dcache_address,
           dcache_wdata, l2_resp, l2_rdata,
    input  icache_resp, icache_rdata, dcache_resp, dcache_rdata, l2_read, l2_write,
           l2_address, l2_wdata, arb_busy
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one L2 port between L1 I-cache and D-cache, alternating on ties
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t            state, state_n;
  logic              last_d, i_req, d_req, grant_d, start, done;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  always_comb begin
    i_req   = bus.icache_read;
    d_req   = bus.dcache_read | bus.dcache_write;
    grant_d = d_req & (~i_req | ~last_d);
    start   = (state == IDLE) & (i_req | d_req);
    done    = (state != IDLE) & bus.l2_resp;
    state_n = state;
    if (start) state_n = grant_d ? SERVE_D : SERVE_I;
    else if (done) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        last_d <= grant_d;
        addr_q <= grant_d ? bus.dcache_address : bus.icache_address;
        rd_q   <= ~grant_d | bus.dcache_read;
        wr_q   <= grant_d & bus.dcache_write;
        if (grant_d & bus.dcache_write) wdata_q <= bus.dcache_wdata;
      end else if (done) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end
    end
  end
  assign bus.l2_read      = rd_q;
  assign bus.l2_write     = wr_q;
  assign bus.l2_address   = addr_q;
  assign bus.l2_wdata     = wdata_q;
  assign bus.icache_resp  = (state == SERVE_I) & bus.l2_resp;
  assign bus.dcache_resp  = (state == SERVE_D) & bus.l2_resp;
  assign bus.icache_rdata = bus.l2_rdata;
  assign bus.dcache_rdata = bus.l2_rdata;
  assign bus.arb_busy     = state != IDLE;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scenarios plus random traffic against a transaction-level model
module tb_cache_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cache_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();
  cache_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int m_owner = 0;
  bit m_last_d = 1'b0;
  bit m_rd = 1'b0;
  bit m_wr = 1'b0;
  logic [15:0] m_addr = '0;
  logic [127:0] m_wdata = '0;
  int got = 0;
  int lat = 0;
  int n = 0;
  logic [31:0] ord = '0;
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask
  task automatic compare_all();
    check("l2_read", bus.l2_read, m_rd);
    check("l2_write", bus.l2_write, m_wr);
    check("l2_address", bus.l2_address, m_addr);
    check("l2_wdata", bus.l2_wdata, m_wdata);
    check("arb_busy", bus.arb_busy, m_owner != 0);
    check("icache_resp", bus.icache_resp, m_owner == 1 && bus.l2_resp);
    check("dcache_resp", bus.dcache_resp, m_owner == 2 && bus.l2_resp);
    check("icache_rdata", bus.icache_rdata, bus.l2_rdata);
    check("dcache_rdata", bus.dcache_rdata, bus.l2_rdata);
  endtask
  task automatic model_update();
    bit i, d, win_d;
    got = 0;
    i = bus.icache_read;
    d = bus.dcache_read | bus.dcache_write;
    if (rst) begin
      m_owner = 0; m_last_d = 0; m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    end else if (m_owner == 0) begin
      if (i || d) begin
        win_d = d && !(i && m_last_d);
        m_owner = win_d ? 2 : 1;
        m_last_d = win_d;
        m_addr = win_d ? bus.dcache_address : bus.icache_address;
        m_rd = !win_d || bus.dcache_read;
        m_wr = win_d && bus.dcache_write;
        if (win_d && bus.dcache_write) m_wdata = bus.dcache_wdata;
      end
    end else if (bus.l2_resp) begin
      got = m_owner;
      m_owner = 0; m_rd = 0; m_wr = 0;
    end
  endtask
  task automatic look();
    #1;
    compare_all();
    if (bus.icache_resp) begin ord = {ord[23:0], "I"}; n++; end
    if (bus.dcache_resp) begin ord = {ord[23:0], "D"}; n++; end
  endtask
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic step();
    look();
    tick();
  endtask
  initial begin
    bus.icache_read = 0; bus.icache_address = '0;
    bus.dcache_read = 0; bus.dcache_write = 0; bus.dcache_address = '0; bus.dcache_wdata = '0;
    bus.l2_resp = 0; bus.l2_rdata = {4{32'hC0DE_0001}};
    tick();
    rst = 0;
    look();
    check("reset_busy", bus.arb_busy, 1'b0);
    check("reset_l2_read", bus.l2_read, 1'b0);
    check("reset_addr", bus.l2_address, 16'h0);
    tick();
    bus.icache_read = 1; bus.icache_address = 16'h3000;
    step();
    look();
    check("i_grant_read", bus.l2_read, 1'b1);
    check("i_grant_addr", bus.l2_address, 16'h3000);
    tick();
    step();
    step();
    bus.l2_resp = 1;
    look();
    check("i_resp", bus.icache_resp, 1'b1);
    check("i_resp_d_quiet", bus.dcache_resp, 1'b0);
    tick();
    bus.icache_read = 0; bus.l2_resp = 0;
    look();
    check("i_done_idle", bus.arb_busy, 1'b0);
    tick();
    bus.dcache_write = 1; bus.dcache_address = 16'h1230; bus.dcache_wdata = {16{8'hA5}};
    step();
    bus.dcache_address = '0; bus.dcache_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      look();
      check("d_hold_write", bus.l2_write, 1'b1);
      check("d_hold_addr", bus.l2_address, 16'h1230);
      check("d_hold_wdata", bus.l2_wdata, {16{8'hA5}});
      tick();
    end
    bus.l2_resp = 1;
    look();
    check("d_resp", bus.dcache_resp, 1'b1);
    check("d_resp_i_quiet", bus.icache_resp, 1'b0);
    tick();
    bus.dcache_write = 0; bus.l2_resp = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    bus.icache_read = 1; bus.dcache_read = 1;
    ord = '0; n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      bus.l2_resp = m_rd | m_wr;
      step();
    end
    check("tie_order", ord, "DIDI");
    bus.icache_read = 0; bus.dcache_read = 0; bus.l2_resp = 0;
    step();
    n = 0;
    for (int k = 0; k < 3; k++) begin
      bus.icache_read = 1;
      step();
      bus.l2_resp = 1;
      look();
      check("lat1_resp", bus.icache_resp, 1'b1);
      tick();
      bus.icache_read = 0; bus.l2_resp = 0;
      look();
      check("lat1_idle_gap", bus.arb_busy, 1'b0);
      tick();
    end
    check("lat1_count", n, 3);
    bus.dcache_read = 1;
    step();
    step();
    step();
    rst = 1;
    step();
    rst = 0; bus.dcache_read = 0;
    look();
    check("rst_mid_read", bus.l2_read, 1'b0);
    check("rst_mid_busy", bus.arb_busy, 1'b0);
    tick();
    bus.l2_resp = 1;
    look();
    check("stale_resp_d", bus.dcache_resp, 1'b0);
    tick();
    look();
    check("idle_resp_i", bus.icache_resp, 1'b0);
    check("idle_resp_d", bus.dcache_resp, 1'b0);
    tick();
    bus.l2_resp = 0;
    look();
    check("idle_stays", bus.arb_busy, 1'b0);
    tick();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (got == 1) bus.icache_read = 0;
      else if (!bus.icache_read && $urandom_range(0, 3) == 0) begin
        bus.icache_read = 1; bus.icache_address = 16'($urandom);
      end else if (bus.icache_read && m_owner == 1 && $urandom_range(0, 15) == 0) bus.icache_read = 0;
      if (got == 2) begin
        bus.dcache_read = 0; bus.dcache_write = 0;
      end else if (!bus.dcache_read && !bus.dcache_write && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) bus.dcache_write = 1; else bus.dcache_read = 1;
        bus.dcache_address = 16'($urandom);
        bus.dcache_wdata = {$urandom, $urandom, $urandom, $urandom};
      end else if (m_owner == 2) begin
        bus.dcache_address = 16'($urandom);
        bus.dcache_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.l2_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (m_rd || m_wr) begin
        if (lat == 0) lat = $urandom_range(1, 4);
        lat--;
        bus.l2_resp = (lat == 0);
      end else begin
        lat = 0;
        bus.l2_resp = ($urandom_range(0, 19) == 0);
      end
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
